icache_sa: RTL and testbench

Parametrised, read-only, N-way set-associative instruction cache with round-robin replacement, flush, and hit/miss counters. It sits between the processor instruction port and the line-oriented main-memory model. It replaces the fixed 8-line direct-mapped cache and generalises sets, ways and line width. Memory refill uses a req/ack handshake instead of a hold-wire protocol.

---
 rtl/icache_pkg.sv | 26 ++
 rtl/icache_way.sv | 57 +++++
 rtl/icache_sa.sv | 186 ++++++++++++++++++
 tb/tb_icache_sa.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
// Address layout, from the top: tag | set index | word offset | byte offset (2 bits).
package icache_pkg;

  typedef enum logic [1:0] {
    ST_LOOKUP,
    ST_REFILL,
    ST_FILL,
    ST_FLUSH
  } icache_state_t;

  localparam logic [31:0] COUNTER_MAX = 32'hFFFF_FFFF;

  // Tag width is what is left of the byte address after index, offset and byte bits.
  function automatic int tag_width(input int addr_w, input int num_sets,
                                   input int words_per_line);
    return addr_w - 2 - $clog2(num_sets) - $clog2(words_per_line);
  endfunction

  // The victim pointer is logically zero-width for a direct-mapped cache.
  // It is kept one bit wide there and simply never advances.
  function automatic int ptr_width(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the cache: per-set valid bit, tag and line storage.
// Reads are combinational; line writes and per-set valid clears are synchronous.
module icache_way
  import icache_pkg::*;
#(
  parameter int NUM_SETS       = 8,
  parameter int WORDS_PER_LINE = 8,
  parameter int IDX_W          = 3,
  parameter int OFF_W          = 3,
  parameter int TAG_W          = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [IDX_W-1:0]              i_rd_idx,
  input  logic [TAG_W-1:0]              i_rd_tag,
  input  logic [OFF_W-1:0]              i_rd_off,
  output logic                          o_hit,
  output logic [31:0]                   o_word,
  input  logic                          i_wr_en,
  input  logic [IDX_W-1:0]              i_wr_idx,
  input  logic [TAG_W-1:0]              i_wr_tag,
  input  logic [32*WORDS_PER_LINE-1:0]  i_wr_line,
  input  logic                          i_clr_en,
  input  logic [IDX_W-1:0]              i_clr_idx
);

  logic [NUM_SETS-1:0]                  r_valid;
  logic [TAG_W-1:0]                     r_tag  [NUM_SETS];
  logic [WORDS_PER_LINE-1:0][31:0]      r_line [NUM_SETS];
  logic [WORDS_PER_LINE-1:0][31:0]      w_line;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else if (i_clr_en) begin
      r_valid[i_clr_idx] <= 1'b0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // NOTE: tag and line arrays are deliberately not reset; the valid bits gate
  // them, and leaving them reset-free lets the arrays map onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_line[i_wr_idx] <= i_wr_line;
    end
  end

  assign w_line = r_line[i_rd_idx];
  assign o_hit  = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_word = w_line[i_rd_off];

endmodule

// File: rtl/icache_sa.sv
// Read-only N-way set-associative instruction cache with round-robin
// replacement, req/ack line refill, whole-cache flush and hit/miss counters.
module icache_sa
  import icache_pkg::*;
#(
  parameter int NUM_SETS       = 8,
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ADDR_W-1:0]             addr,
  inout  wire  [31:0]                   data,
  input  logic                          ce_n,
  input  logic                          oe_n,
  input  logic                          flush,
  output logic                          hold_o,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ack,
  input  logic [32*WORDS_PER_LINE-1:0]  mem_line,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt
);

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(NUM_SETS);
  localparam int TAG_W   = tag_width(ADDR_W, NUM_SETS, WORDS_PER_LINE);
  localparam int PTR_W   = ptr_width(NUM_WAYS);
  localparam int IDX_LSB = OFF_W + 2;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  icache_state_t                  r_state;
  logic                           r_mem_req;
  logic [ADDR_W-1:0]              r_mem_addr;
  logic [32*WORDS_PER_LINE-1:0]   r_line_buf;
  logic                           r_flush_pend;
  logic [IDX_W-1:0]               r_flush_set;
  logic [PTR_W-1:0]               r_victim [NUM_SETS];
  logic [31:0]                    r_hit_cnt;
  logic [31:0]                    r_miss_cnt;

  logic [OFF_W-1:0]               w_off;
  logic [IDX_W-1:0]               w_idx;
  logic [TAG_W-1:0]               w_tag;
  logic [IDX_W-1:0]               w_fill_idx;
  logic [TAG_W-1:0]               w_fill_tag;
  logic [NUM_WAYS-1:0]            w_way_hit;
  logic [31:0]                    w_way_word [NUM_WAYS];
  logic [31:0]                    w_word;
  logic                           w_lookup;
  logic                           w_fill;
  logic                           w_clear;
  logic                           w_hit;
  logic                           w_miss;
  logic                           w_unused;

  assign w_off      = addr[IDX_LSB-1:2];
  assign w_idx      = addr[TAG_LSB-1:IDX_LSB];
  assign w_tag      = addr[ADDR_W-1:TAG_LSB];
  assign w_unused   = ^addr[1:0];
  // The fill targets the set latched with the refill address, not the live bus.
  assign w_fill_idx = r_mem_addr[TAG_LSB-1:IDX_LSB];
  assign w_fill_tag = r_mem_addr[ADDR_W-1:TAG_LSB];

  assign w_lookup = (r_state == ST_LOOKUP);
  assign w_fill   = (r_state == ST_FILL);
  assign w_clear  = (r_state == ST_FLUSH);

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    logic w_wr_en;
    assign w_wr_en = w_fill && (r_victim[w_fill_idx] == PTR_W'(g));

    icache_way #(
      .NUM_SETS       (NUM_SETS),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .IDX_W          (IDX_W),
      .OFF_W          (OFF_W),
      .TAG_W          (TAG_W)
    ) u_way (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_rd_idx  (w_idx),
      .i_rd_tag  (w_tag),
      .i_rd_off  (w_off),
      .o_hit     (w_way_hit[g]),
      .o_word    (w_way_word[g]),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (w_fill_idx),
      .i_wr_tag  (w_fill_tag),
      .i_wr_line (r_line_buf),
      .i_clr_en  (w_clear),
      .i_clr_idx (r_flush_set)
    );
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_word = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (w_way_hit[w]) w_word = w_word | w_way_word[w];
    end
  end

  assign w_hit  = w_lookup && !ce_n && (|w_way_hit);
  // A flush in LOOKUP pre-empts the access, so it is not counted as a miss.
  assign w_miss = w_lookup && !ce_n && !(|w_way_hit) && !flush;

  assign hold_o   = (!ce_n && !w_hit) || !w_lookup;
  assign data     = (!ce_n && !oe_n && w_hit) ? w_word : 'z;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_LOOKUP;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_line_buf   <= '0;
      r_flush_pend <= 1'b0;
      r_flush_set  <= '0;
    end else begin
      case (r_state)
        ST_LOOKUP: begin
          if (flush) begin
            r_state     <= ST_FLUSH;
            r_flush_set <= '0;
          end else if (w_miss) begin
            r_state    <= ST_REFILL;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
          end
        end
        ST_REFILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_ack) begin
            r_line_buf <= mem_line;
            r_mem_req  <= 1'b0;
            r_state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          r_flush_set <= '0;
          if (r_flush_pend || flush) begin
            r_state      <= ST_FLUSH;
            r_flush_pend <= 1'b0;
          end else begin
            r_state <= ST_LOOKUP;
          end
        end
        ST_FLUSH: begin
          r_flush_set <= r_flush_set + 1'b1;
          if (r_flush_set == IDX_W'(NUM_SETS - 1)) r_state <= ST_LOOKUP;
        end
        default: r_state <= ST_LOOKUP;
      endcase
    end
  end

  // Round-robin victim per set; the flush walk also rewinds each set's pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) r_victim[s] <= '0;
    end else if (w_fill) begin
      r_victim[w_fill_idx] <= (r_victim[w_fill_idx] == PTR_W'(NUM_WAYS - 1))
                              ? '0 : r_victim[w_fill_idx] + 1'b1;
    end else if (w_clear) begin
      r_victim[r_flush_set] <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit && (r_hit_cnt != COUNTER_MAX))   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != COUNTER_MAX)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench for icache_sa: a behavioural cache model predicts hits,
// misses, stall lengths and counters; expected words are queued per fetch.
module tb_icache_sa;

  localparam int NUM_SETS       = 8;
  localparam int NUM_WAYS       = 2;
  localparam int WORDS_PER_LINE = 8;
  localparam int ADDR_W         = 32;
  localparam int OFF_W          = $clog2(WORDS_PER_LINE);
  localparam int IDX_W          = $clog2(NUM_SETS);
  localparam logic [31:0] LINE_MASK = ~32'(4 * WORDS_PER_LINE - 1);

  logic                         clk = 1'b0;
  logic                         reset_n = 1'b0;
  logic [ADDR_W-1:0]            addr = '0;
  wire  [31:0]                  data;
  logic                         ce_n = 1'b1;
  logic                         oe_n = 1'b1;
  logic                         flush = 1'b0;
  logic                         hold_o;
  logic                         mem_req;
  logic [ADDR_W-1:0]            mem_addr;
  logic                         mem_ack = 1'b0;
  logic [32*WORDS_PER_LINE-1:0] mem_line = '1;
  logic [31:0]                  hit_cnt;
  logic [31:0]                  miss_cnt;

  icache_sa #(
    .NUM_SETS       (NUM_SETS),
    .NUM_WAYS       (NUM_WAYS),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr     (addr),
    .data     (data),
    .ce_n     (ce_n),
    .oe_n     (oe_n),
    .flush    (flush),
    .hold_o   (hold_o),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_line (mem_line),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_dly  = 1;
  int          req_cycles = 0;
  logic [31:0] sb_q [$];
  logic [31:0] exp_hit  = '0;
  logic [31:0] exp_miss = '0;

  bit          m_valid [NUM_SETS][NUM_WAYS];
  logic [31:0] m_tag   [NUM_SETS][NUM_WAYS];
  int          m_vict  [NUM_SETS];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h0040_0004) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [32*WORDS_PER_LINE-1:0] line_of(input logic [31:0] la);
    logic [32*WORDS_PER_LINE-1:0] l;
    for (int i = 0; i < WORDS_PER_LINE; i++) l[32*i +: 32] = word_of(la + 32'(4 * i));
    return l;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NUM_SETS; s++) begin
      m_vict[s] = 0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_tag[s][w]   = '0;
      end
    end
  endfunction

  // Returns 1 on a miss and installs the line in the round-robin victim way.
  function automatic bit model_access(input logic [31:0] a);
    int          s;
    logic [31:0] t;
    s = int'((a >> (2 + OFF_W)) & 32'(NUM_SETS - 1));
    t = a >> (2 + OFF_W + IDX_W);
    for (int w = 0; w < NUM_WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) return 1'b0;
    m_valid[s][m_vict[s]] = 1'b1;
    m_tag[s][m_vict[s]]   = t;
    m_vict[s]             = (m_vict[s] + 1) % NUM_WAYS;
    return 1'b1;
  endfunction

  // Memory responder: acks ack_dly cycles into a request with the addressed line.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && !mem_ack) begin
        req_cycles++;
        if (req_cycles == ack_dly) begin
          mem_ack  = 1'b1;
          mem_line = line_of(mem_addr);
        end
      end else begin
        mem_ack    = 1'b0;
        mem_line   = '1;
        req_cycles = 0;
      end
    end
  end

  // Output monitor: every read hit pops one expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && !ce_n && !oe_n && !hold_o) begin
        if (sb_q.size() == 0) check("sb_underflow", 32'(sb_q.size()), 32'd1);
        else                  check("data", data, sb_q.pop_front());
      end
    end
  end

  task automatic fetch(input logic [31:0] a);
    bit miss;
    int stalls;
    bit seen_req;
    miss = model_access(a);
    if (miss) exp_miss = sat_inc(exp_miss);
    exp_hit = sat_inc(exp_hit);
    sb_q.push_back(word_of(a));
    @(posedge clk); #1;
    addr = a; ce_n = 1'b0; oe_n = 1'b0;
    stalls = 0; seen_req = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!hold_o) break;
      stalls++;
      if (mem_req && !seen_req) begin
        seen_req = 1'b1;
        check("mem_addr", mem_addr, a & LINE_MASK);
      end
    end
    check("fetch_hold_end", 32'(hold_o), 32'd0);
    check("stall_cycles", 32'(stalls), miss ? 32'(ack_dly + 2) : 32'd0);
    @(posedge clk); #1;
    ce_n = 1'b1; oe_n = 1'b1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hit_cnt"}, hit_cnt, exp_hit);
    check({tag, "_miss_cnt"}, miss_cnt, exp_miss);
  endtask

  task automatic wait_req(input string tag);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    check(tag, 32'(mem_req), 32'd1);
  endtask

  initial begin
    int cnt;
    logic [31:0] a;
    model_reset();

    // Reset state
    #12;
    check("rst_hold_idle", 32'(hold_o), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check_counters("rst");
    ce_n = 1'b0; #1;
    check("rst_hold_ce", 32'(hold_o), 32'd1);
    ce_n = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;

    // Cold miss with a slow acknowledge
    ack_dly = 5;
    fetch(32'h0040_0004);
    check_counters("cold");
    ack_dly = 1;

    // Two tags sharing set 0 coexist, then round-robin eviction
    fetch(32'h0040_0000);
    fetch(32'h0040_0100);
    fetch(32'h0040_0000);
    fetch(32'h0040_011C);
    fetch(32'h0040_0200);
    fetch(32'h0040_0200);
    fetch(32'h0040_0000);
    fetch(32'h0040_0100);
    check_counters("rr");

    // Mixed traffic over a few sets and tags
    for (int i = 0; i < 16; i++) begin
      a = 32'h0040_0000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 3)) << 5)
          + (32'($urandom_range(0, WORDS_PER_LINE - 1)) << 2);
      fetch(a);
    end
    check_counters("mixed");

    // Flush from idle
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!hold_o) break;
      cnt++;
    end
    check("idle_flush_cycles", 32'(cnt), 32'(NUM_SETS));
    model_reset();
    fetch(32'h0040_0000);

    // Flush arriving mid-refill; processor drops ce_n during the refill
    a = 32'h0040_0840;
    if (model_access(a)) exp_miss = sat_inc(exp_miss);
    ack_dly = 3;
    @(posedge clk); #1;
    addr = a; ce_n = 1'b0; oe_n = 1'b1;
    wait_req("fl_req");
    check("fl_mem_addr", mem_addr, a & LINE_MASK);
    @(posedge clk); #1 flush = 1'b1; ce_n = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!hold_o) break;
      if (!mem_req) cnt++;
    end
    check("fl_hold_end", 32'(hold_o), 32'd0);
    check("fl_fill_flush_cycles", 32'(cnt), 32'(1 + NUM_SETS));
    model_reset();
    fetch(a);
    check_counters("flush");
    ack_dly = 1;

    // Asynchronous reset while a refill is outstanding
    ack_dly = 1000;
    @(posedge clk); #1;
    addr = 32'h0040_0060; ce_n = 1'b0; oe_n = 1'b1;
    wait_req("ar_req");
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    check("ar_mem_req", 32'(mem_req), 32'd0);
    check("ar_hit_cnt", hit_cnt, 32'd0);
    check("ar_miss_cnt", miss_cnt, 32'd0);
    check("ar_hold_ce", 32'(hold_o), 32'd1);
    ce_n = 1'b1; #1;
    check("ar_hold_idle", 32'(hold_o), 32'd0);
    check("ar_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    model_reset();
    exp_hit = '0; exp_miss = '0;
    ack_dly = 1;

    // Counter saturation
    fetch(32'h0040_0000);
    @(posedge clk); #1;
    force dut.r_hit_cnt = 32'hFFFF_FFFE;
    force dut.r_miss_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_hit_cnt;
    release dut.r_miss_cnt;
    exp_hit = 32'hFFFF_FFFE; exp_miss = 32'hFFFF_FFFE;
    check_counters("sat_forced");
    for (int i = 0; i < 3; i++) fetch(32'h0040_0000);
    check("sat_hit_cnt", hit_cnt, 32'hFFFF_FFFF);
    check("sat_miss_hold", miss_cnt, 32'hFFFF_FFFE);
    fetch(32'h0040_0020);
    fetch(32'h0040_0040);
    check("sat_miss_cnt", miss_cnt, 32'hFFFF_FFFF);
    check_counters("sat");

    repeat (2) @(posedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
